regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single register-file write port (we3/wa3/wd3) between two requesters: the ALU result path (port A) and the memory-load path (port B). Each requester has a one-entry holding buffer with a valid/ready handshake. The arbiter grants one buffered write per cycle and drives registered write controls into the register file. It also flags reads that hit a not-yet-committed write so the read side can stall.

---
 rtl/regfile_wb_arbiter_if.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the requester handshakes, register-file write port and hazard
// lookup shared between the write-back arbiter and its surroundings.
// slave : the arbiter side.  master : requesters, register file and read stage.
interface regfile_wb_arbiter_if #(
  parameter int W  = 64,
  parameter int AW = 5
);
  // ALU result path (port A)
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_data;

  // Memory-load path (port B)
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_data;

  // Registered register-file write port
  logic          we3;
  logic [AW-1:0] wa3;
  logic [W-1:0]  wd3;

  // Read-side hazard lookup
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          pend1;
  logic          pend2;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  ra1, ra2,
    output a_ready, b_ready,
    output we3, wa3, wd3,
    output pend1, pend2
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output ra1, ra2,
    input  a_ready, b_ready,
    input  we3, wa3, wd3,
    input  pend1, pend2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// ALU path (A) and the load path (B). Each port owns a one-entry buffer; one
// buffered write per cycle is moved into the registered we3/wa3/wd3 outputs.
// Writes to XZR (all-ones address) are accepted and discarded.
// pend1/pend2 flag reads of registers that still have an uncommitted write.
//
// Build option: define WB_ARB_RR_EN for round-robin arbitration on conflicts.
// Without it, port B (load) wins every conflict.
module regfile_wb_arbiter #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [AW-1:0] XZR = '1;

  // Per-port holding buffers
  logic          full_a, full_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [W-1:0]  data_a, data_b;

  // Handshake and arbitration
  logic          ready_a, ready_b;
  logic          xfer_a, xfer_b;
  logic          grant_a, grant_b;

  // Registered write port
  logic          we3_q;
  logic [AW-1:0] wa3_q;
  logic [W-1:0]  wd3_q;

  // A buffer being granted this cycle frees its slot, so it can refill at the
  // same edge. Ready is forced low while reset is held.
  assign ready_a = !reset && (!full_a || grant_a);
  assign ready_b = !reset && (!full_b || grant_b);
  assign xfer_a  = bus.a_valid && ready_a;
  assign xfer_b  = bus.b_valid && ready_b;

  // Buffer occupancy: a new transfer overrides a drain; XZR transfers leave it empty.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (reset) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
    end else begin
      if (xfer_a)       full_a <= (bus.a_addr != XZR);
      else if (grant_a) full_a <= 1'b0;
      if (xfer_b)       full_b <= (bus.b_addr != XZR);
      else if (grant_b) full_b <= 1'b0;
    end
  end

  // Buffer payload capture on every accepted transfer.
  always_ff @(posedge clk) begin
    // NOTE: the payload has no reset; it is only ever observed through the
    // full flags, which are reset, so clearing it would buy nothing.
    if (xfer_a) begin
      addr_a <= bus.a_addr;
      data_a <= bus.a_data;
    end
    if (xfer_b) begin
      addr_b <= bus.b_addr;
      data_b <= bus.b_data;
    end
  end

`ifdef WB_ARB_RR_EN
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t last_q, last_d;

  // Round-robin grant: on a conflict the port not granted last wins.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    last_d  = last_q;
    if (full_a && full_b) begin
      if (last_q == LAST_A) begin
        grant_b = 1'b1;
        last_d  = LAST_B;
      end else begin
        grant_a = 1'b1;
        last_d  = LAST_A;
      end
    end else begin
      grant_a = full_a;
      grant_b = full_b;
    end
  end

  // Round-robin pointer; it only moves on conflict grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= LAST_A;
    else       last_q <= last_d;
  end
`else
  // Fixed priority grant: the load path wins every conflict.
  always_comb begin
    grant_b = full_b;
    grant_a = full_a && !full_b;
  end
`endif

  // Output register: load the granted entry, otherwise drop we3 and keep wa3/wd3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else if (grant_b) begin
      we3_q <= 1'b1;
      wa3_q <= addr_b;
      wd3_q <= data_b;
    end else if (grant_a) begin
      we3_q <= 1'b1;
      wa3_q <= addr_a;
      wd3_q <= data_a;
    end else begin
      we3_q <= 1'b0;
    end
  end

  assign bus.a_ready = ready_a;
  assign bus.b_ready = ready_b;
  assign bus.we3     = we3_q;
  assign bus.wa3     = wa3_q;
  assign bus.wd3     = wd3_q;

  // Hazard flags: a read hits a buffered write or the write being committed.
  assign bus.pend1 = (bus.ra1 != XZR) &&
                     ((full_a && (bus.ra1 == addr_a)) ||
                      (full_b && (bus.ra1 == addr_b)) ||
                      (we3_q  && (bus.ra1 == wa3_q)));
  assign bus.pend2 = (bus.ra2 != XZR) &&
                     ((full_a && (bus.ra2 == addr_a)) ||
                      (full_b && (bus.ra2 == addr_b)) ||
                      (we3_q  && (bus.ra2 == wa3_q)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A transaction-level model
// (port arrays, winner selection) tracks what the outputs must be and is
// compared every cycle on the falling edge; directed checks pin key values.
// Define WB_ARB_RR_EN for both bench and RTL to test the round-robin build.
module tb_regfile_wb_arbiter;
  localparam int W  = 64;
  localparam int AW = 5;
  localparam logic [AW-1:0] ZR = 5'd31;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.W(W), .AW(AW)) bus ();

  regfile_wb_arbiter #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: index 0 = port A, 1 = port B ----------------
  bit            m_full [2] = '{1'b0, 1'b0};
  logic [AW-1:0] m_addr [2];
  logic [W-1:0]  m_data [2];
  bit            m_we   = 1'b0;
  logic [AW-1:0] m_wa   = '0;
  logic [W-1:0]  m_wd   = '0;
  int            m_last = 0;

  function automatic int m_winner();
    if (m_full[0] && m_full[1]) begin
`ifdef WB_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int p);
    if (reset) return 1'b0;
    return !m_full[p] || (m_winner() == p);
  endfunction

  function automatic bit m_pend(input logic [AW-1:0] ra);
    if (ra == ZR) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (m_full[p] && m_addr[p] == ra) return 1'b1;
    return m_we && (m_wa == ra);
  endfunction

  function automatic bit in_valid(input int p);
    return (p == 0) ? bus.a_valid : bus.b_valid;
  endfunction

  function automatic logic [AW-1:0] in_addr(input int p);
    return (p == 0) ? bus.a_addr : bus.b_addr;
  endfunction

  function automatic logic [W-1:0] in_data(input int p);
    return (p == 0) ? bus.a_data : bus.b_data;
  endfunction

  // Model update: winner moves to output; accepted non-XZR writes fill buffers.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_full[0] <= 1'b0;
      m_full[1] <= 1'b0;
      m_we      <= 1'b0;
      m_wa      <= '0;
      m_wd      <= '0;
      m_last    <= 0;
    end else begin
      if (m_winner() >= 0) begin
        m_we                 <= 1'b1;
        m_wa                 <= m_addr[m_winner()];
        m_wd                 <= m_data[m_winner()];
        m_full[m_winner()]   <= 1'b0;
        if (m_full[0] && m_full[1]) m_last <= m_winner();
      end else begin
        m_we <= 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (in_valid(p) && m_ready(p) && in_addr(p) != ZR) begin
          m_full[p] <= 1'b1;
          m_addr[p] <= in_addr(p);
          m_data[p] <= in_data(p);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      check("cmp a_ready", bus.a_ready, m_ready(0));
      check("cmp b_ready", bus.b_ready, m_ready(1));
      check("cmp we3",     bus.we3,     m_we);
      check("cmp wa3",     bus.wa3,     m_wa);
      check("cmp wd3",     bus.wd3,     m_wd);
      check("cmp pend1",   bus.pend1,   m_pend(bus.ra1));
      check("cmp pend2",   bus.pend2,   m_pend(bus.ra2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Conflict A(3,0xA) vs B(4,0xB); first_b selects the expected issue order.
  task automatic conflict(input string tag, input bit first_b);
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'hA;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 64'hB;
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    check({tag, " loser ready"}, first_b ? bus.a_ready : bus.b_ready, 1'b0);
    step();
    @(negedge clk);
    check({tag, " first we3"}, bus.we3, 1'b1);
    check({tag, " first wa3"}, bus.wa3, first_b ? 5'd4 : 5'd3);
    step();
    @(negedge clk);
    check({tag, " second we3"}, bus.we3, 1'b1);
    check({tag, " second wa3"}, bus.wa3, first_b ? 5'd3 : 5'd4);
    idle(2);
  endtask

  initial begin
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.ra1 = 5'd1; bus.ra2 = 5'd2;
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset a_ready", bus.a_ready, 1'b0);
    check("reset b_ready", bus.b_ready, 1'b0);
    check("reset we3",     bus.we3,     1'b0);
    check("reset wa3",     bus.wa3,     5'd0);
    check("reset wd3",     bus.wd3,     64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    started = 1'b1;
    idle(2);

    // Single write A(5, 0x55)
    bus.ra1 = 5'd5;
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'h55;
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("single pend after E0", bus.pend1, 1'b1);
    check("single we3 after E0",  bus.we3,   1'b0);
    step();
    @(negedge clk);
    check("single we3 after E1",  bus.we3,   1'b1);
    check("single wa3 after E1",  bus.wa3,   5'd5);
    check("single wd3 after E1",  bus.wd3,   64'h55);
    check("single pend after E1", bus.pend1, 1'b1);
    step();
    @(negedge clk);
    check("single we3 after E2",  bus.we3,   1'b0);
    check("single pend after E2", bus.pend1, 1'b0);
    check("single wd3 held",      bus.wd3,   64'h55);
    idle(2);

    // Back-to-back conflicts
    conflict("conflict1", 1'b1);
`ifdef WB_ARB_RR_EN
    conflict("conflict2", 1'b0);
`else
    conflict("conflict2", 1'b1);
`endif

    // XZR drop
    bus.ra1 = ZR;
    bus.b_valid = 1'b1; bus.b_addr = ZR; bus.b_data = 64'hDEAD;
    @(negedge clk);
    check("xzr b_ready before", bus.b_ready, 1'b1);
    step();
    bus.b_valid = 1'b0;
    @(negedge clk);
    check("xzr b_ready after", bus.b_ready, 1'b1);
    check("xzr we3 E0",        bus.we3,     1'b0);
    check("xzr pend1",         bus.pend1,   1'b0);
    step();
    @(negedge clk);
    check("xzr we3 E1",        bus.we3,     1'b0);
    idle(2);

    // Streaming A, addrs 0..7
    bus.ra1 = 5'd1;
    for (int i = 0; i < 8; i++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'(i); bus.a_data = 64'h100 + 64'(i);
      @(negedge clk);
      check("stream a_ready", bus.a_ready, 1'b1);
      if (i >= 2) begin
        check("stream we3", bus.we3, 1'b1);
        check("stream wa3", bus.wa3, 5'(i - 2));
      end
      step();
    end
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("stream tail we3 6", bus.we3, 1'b1);
    check("stream tail wa3 6", bus.wa3, 5'd6);
    step();
    @(negedge clk);
    check("stream tail wa3 7", bus.wa3, 5'd7);
    check("stream tail wd3 7", bus.wd3, 64'h107);
    step();
    @(negedge clk);
    check("stream end we3", bus.we3, 1'b0);
    idle(2);

    // Reset in the cycle after E0 of a buffered write
    bus.ra1 = 5'd9;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 64'h99;
    step();
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("rst pend before", bus.pend1, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst pend during",    bus.pend1,   1'b0);
    check("rst we3 during",     bus.we3,     1'b0);
    check("rst a_ready during", bus.a_ready, 1'b0);
    check("rst b_ready during", bus.b_ready, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst no late we3",  bus.we3,   1'b0);
      check("rst no late pend", bus.pend1, 1'b0);
      step();
    end

    // Same-address ordering: A(7,1) vs B(7,2)
    bus.ra2 = 5'd7;
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 64'd1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'd2;
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(negedge clk);
    check("same pend2 E0", bus.pend2, 1'b1);
    step();
    @(negedge clk);
    check("same first wd3",  bus.wd3,   64'd2);
    check("same first we3",  bus.we3,   1'b1);
    check("same pend2 E1",   bus.pend2, 1'b1);
    step();
    @(negedge clk);
    check("same second wd3", bus.wd3,   64'd1);
    check("same pend2 E2",   bus.pend2, 1'b1);
    step();
    @(negedge clk);
    check("same done we3",   bus.we3,   1'b0);
    check("same pend2 E3",   bus.pend2, 1'b0);
    check("same final wd3",  bus.wd3,   64'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
